regs_dbg_access: RTL and testbench

- Initiator-side access engine for the general-purpose register file; serves debug host requests to read or write x0..x31.
- Each accepted request halts the core, then borrows the register file's write port (shared with ex) or read port 2 (shared with id).
- Returns one response per request, then releases the halt.
- Sits between the debug transport module and the register file, in the core top level.

---
 rtl/regs_dbg_access_if.sv | 42 ++++
 rtl/regs_dbg_access.sv | 115 +++++++++++
 tb/tb_regs_dbg_access.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regs_dbg_access_if.sv
// rtl/regs_dbg_access_if.sv - debug request/response and register-file port bundle for regs_dbg_access
interface regs_dbg_access_if #(
  parameter int DW = 32,
  parameter int AW = 5
) ();
  logic          dbg_req_valid_i;
  logic          dbg_req_ready_o;
  logic          dbg_req_we_i;
  logic [AW-1:0] dbg_req_addr_i;
  logic [DW-1:0] dbg_req_wdata_i;
  logic          dbg_rsp_valid_o;
  logic          dbg_rsp_ready_i;
  logic [DW-1:0] dbg_rsp_rdata_o;
  logic          dbg_rsp_err_o;
  logic          halt_o;
  logic          halted_i;
  logic          ex_we_i;
  logic [AW-1:0] ex_waddr_i;
  logic [DW-1:0] ex_wdata_i;
  logic          regs_we_o;
  logic [AW-1:0] regs_waddr_o;
  logic [DW-1:0] regs_wdata_o;
  logic [AW-1:0] id_raddr2_i;
  logic [AW-1:0] regs_raddr2_o;
  logic [DW-1:0] regs_rdata2_i;

  modport slave (
    input  dbg_req_valid_i, dbg_req_we_i, dbg_req_addr_i, dbg_req_wdata_i,
    input  dbg_rsp_ready_i, halted_i, ex_we_i, ex_waddr_i, ex_wdata_i,
    input  id_raddr2_i, regs_rdata2_i,
    output dbg_req_ready_o, dbg_rsp_valid_o, dbg_rsp_rdata_o, dbg_rsp_err_o,
    output halt_o, regs_we_o, regs_waddr_o, regs_wdata_o, regs_raddr2_o
  );

  modport master (
    output dbg_req_valid_i, dbg_req_we_i, dbg_req_addr_i, dbg_req_wdata_i,
    output dbg_rsp_ready_i, halted_i, ex_we_i, ex_waddr_i, ex_wdata_i,
    output id_raddr2_i, regs_rdata2_i,
    input  dbg_req_ready_o, dbg_rsp_valid_o, dbg_rsp_rdata_o, dbg_rsp_err_o,
    input  halt_o, regs_we_o, regs_waddr_o, regs_wdata_o, regs_raddr2_o
  );
endinterface

// File: rtl/regs_dbg_access.sv
// rtl/regs_dbg_access.sv - debug-host access engine for the GPR file; halts the core and borrows its ports
module regs_dbg_access #(
  parameter int DW           = 32,
  parameter int AW           = 5,
  parameter int HALT_TIMEOUT = 255,
  parameter int TW           = 8
) (
  input logic              clk,
  input logic              rst,
  regs_dbg_access_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HALT, ACCESS, RESP} state_t;

  localparam logic [TW-1:0] TIMER_LAST = TW'(HALT_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          issue_wr;
  logic          issue_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dbg_req_valid_i) begin
          we_d    = bus.dbg_req_we_i;
          addr_d  = bus.dbg_req_addr_i;
          wdata_d = bus.dbg_req_wdata_i;
          timer_d = '0;
          state_d = HALT;
        end
      end
      HALT: begin
        if (bus.halted_i) begin
          state_d = ACCESS;
        end else if (timer_q == TIMER_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ACCESS: begin
        if (we_q) begin
          // ex writeback owns the write port; the debug write waits for a free cycle
          if (!bus.ex_we_i) begin
            issue_wr = 1'b1;
            rdata_d  = '0;
            err_d    = 1'b0;
            state_d  = RESP;
          end
        end else begin
          issue_rd = 1'b1;
          rdata_d  = bus.regs_rdata2_i;
          err_d    = 1'b0;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (bus.dbg_rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dbg_req_ready_o = (state_q == IDLE) && !rst;
  assign bus.dbg_rsp_valid_o = (state_q == RESP);
  assign bus.dbg_rsp_rdata_o = rdata_q;
  assign bus.dbg_rsp_err_o   = err_q;
  assign bus.halt_o          = (state_q != IDLE);

  // write port is silenced during reset so an aborted access can never leak a write
  assign bus.regs_we_o       = !rst && (issue_wr || bus.ex_we_i);
  assign bus.regs_waddr_o    = issue_wr ? addr_q  : bus.ex_waddr_i;
  assign bus.regs_wdata_o    = issue_wr ? wdata_q : bus.ex_wdata_i;
  assign bus.regs_raddr2_o   = issue_rd ? addr_q  : bus.id_raddr2_i;

endmodule

// File: tb/tb_regs_dbg_access.sv
// tb/tb_regs_dbg_access.sv - self-checking bench for regs_dbg_access
module tb_regs_dbg_access;

  logic clk = 1'b0;
  logic rst;
  logic rf_clr;
  always #5 clk = ~clk;

  regs_dbg_access_if #(.DW(32), .AW(5)) bus ();

  regs_dbg_access #(.DW(32), .AW(5), .HALT_TIMEOUT(255), .TW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // register file environment: x0 reads zero, write-to-read forwarding
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.regs_we_o && bus.regs_waddr_o != 5'd0) begin
      rf[bus.regs_waddr_o] <= bus.regs_wdata_o;
    end
  end
  always_comb begin
    bus.regs_rdata2_i = '0;
    if (bus.regs_raddr2_o != 5'd0) begin
      if (bus.regs_we_o && bus.regs_waddr_o == bus.regs_raddr2_o)
        bus.regs_rdata2_i = bus.regs_wdata_o;
      else
        bus.regs_rdata2_i = rf[bus.regs_raddr2_o];
    end
  end

  int dbg_wr_cnt = 0;
  always @(posedge clk) begin
    if (!rst && bus.regs_we_o && !bus.ex_we_i) dbg_wr_cnt <= dbg_wr_cnt + 1;
  end

  logic [31:0] exp_regs [32];
  int checks = 0;
  int errors = 0;

  task automatic do_req(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                        input int hdelay, output logic [31:0] rdata, output logic err,
                        output int lat, output logic halt_at_rsp);
    bus.halted_i        = (hdelay == 0);
    bus.dbg_req_valid_i = 1'b1;
    bus.dbg_req_we_i    = we;
    bus.dbg_req_addr_i  = addr;
    bus.dbg_req_wdata_i = wdata;
    @(posedge clk); #1;
    bus.dbg_req_valid_i = 1'b0;
    lat = 0;
    while (!bus.dbg_rsp_valid_o && lat < 600) begin
      lat++;
      if (lat == hdelay) bus.halted_i = 1'b1;
      @(posedge clk); #1;
    end
    rdata       = bus.dbg_rsp_rdata_o;
    err         = bus.dbg_rsp_err_o;
    halt_at_rsp = bus.halt_o;
    bus.dbg_rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.dbg_rsp_ready_i = 1'b0;
    bus.halted_i        = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rf_clr = 1'b1;
    bus.dbg_req_valid_i = 1'b0; bus.dbg_req_we_i = 1'b0; bus.dbg_req_addr_i = '0;
    bus.dbg_req_wdata_i = '0; bus.dbg_rsp_ready_i = 1'b0; bus.halted_i = 1'b1;
    bus.ex_we_i = 1'b1; bus.ex_waddr_i = 5'd4; bus.ex_wdata_i = 32'h5a5a;
    bus.id_raddr2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.dbg_req_ready_o !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %0b want 0", bus.dbg_req_ready_o); end
    checks++; if (bus.regs_we_o !== 1'b0) begin errors++; $display("FAIL rst_regs_we got %0b want 0", bus.regs_we_o); end
    rst = 1'b0; rf_clr = 1'b0; bus.ex_we_i = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.halt_o !== 1'b0) begin errors++; $display("FAIL reset_halt got %0b want 0", bus.halt_o); end
    checks++; if (bus.dbg_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", bus.dbg_rsp_valid_o); end
    checks++; if (bus.dbg_rsp_rdata_o !== 32'h0 || bus.dbg_rsp_err_o !== 1'b0) begin errors++; $display("FAIL reset_rsp got rdata=%h err=%0b want 0/0", bus.dbg_rsp_rdata_o, bus.dbg_rsp_err_o); end
    checks++; if (bus.dbg_req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b want 1", bus.dbg_req_ready_o); end
  endtask

  task automatic test_write_latency();
    logic [31:0] rd; logic er; int lat; logic h;
    int cnt0 = dbg_wr_cnt;
    bus.halted_i = 1'b1;
    bus.dbg_req_valid_i = 1'b1; bus.dbg_req_we_i = 1'b1;
    bus.dbg_req_addr_i = 5'd5; bus.dbg_req_wdata_i = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.dbg_req_valid_i = 1'b0;
    checks++; if (bus.halt_o !== 1'b1 || bus.regs_we_o !== 1'b0) begin errors++; $display("FAIL lat_t1 got halt=%0b we=%0b want 1/0", bus.halt_o, bus.regs_we_o); end
    @(posedge clk); #1;
    checks++; if (bus.regs_we_o !== 1'b1 || bus.regs_waddr_o !== 5'd5 || bus.regs_wdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL lat_t2_write got we=%0b addr=%0d data=%h want 1/5/deadbeef", bus.regs_we_o, bus.regs_waddr_o, bus.regs_wdata_o); end
    @(posedge clk); #1;
    checks++; if (bus.regs_we_o !== 1'b0 || bus.dbg_rsp_valid_o !== 1'b1 || bus.dbg_rsp_err_o !== 1'b0 || bus.dbg_rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL lat_t3_rsp got we=%0b valid=%0b err=%0b rdata=%h want 0/1/0/0", bus.regs_we_o, bus.dbg_rsp_valid_o, bus.dbg_rsp_err_o, bus.dbg_rsp_rdata_o); end
    bus.dbg_rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.dbg_rsp_ready_i = 1'b0;
    checks++; if (bus.halt_o !== 1'b0 || bus.dbg_req_ready_o !== 1'b1) begin errors++; $display("FAIL lat_t4_idle got halt=%0b ready=%0b want 0/1", bus.halt_o, bus.dbg_req_ready_o); end
    checks++; if (dbg_wr_cnt - cnt0 !== 1) begin errors++; $display("FAIL lat_write_pulses got %0d want 1", dbg_wr_cnt - cnt0); end
    exp_regs[5] = 32'hDEADBEEF;
    do_req(1'b0, 5'd5, 32'h0, 0, rd, er, lat, h);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 2) begin errors++; $display("FAIL read_x5 got rdata=%h err=%0b lat=%0d want deadbeef/0/2", rd, er, lat); end
  endtask

  task automatic test_x0();
    logic [31:0] rd; logic er; int lat; logic h;
    int cnt0 = dbg_wr_cnt;
    do_req(1'b1, 5'd0, 32'hFFFFFFFF, 0, rd, er, lat, h);
    checks++; if (er !== 1'b0 || rd !== 32'h0 || dbg_wr_cnt - cnt0 !== 1) begin errors++; $display("FAIL write_x0 got err=%0b rdata=%h pulses=%0d want 0/0/1", er, rd, dbg_wr_cnt - cnt0); end
    cnt0 = dbg_wr_cnt;
    do_req(1'b0, 5'd0, 32'h0, 0, rd, er, lat, h);
    checks++; if (rd !== 32'h0 || er !== 1'b0 || dbg_wr_cnt != cnt0) begin errors++; $display("FAIL read_x0 got rdata=%h err=%0b pulses=%0d want 0/0/0", rd, er, dbg_wr_cnt - cnt0); end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic er; int lat; logic h;
    for (int n = 0; n < 24; n++) begin
      logic        we    = 1'($urandom);
      logic [4:0]  addr  = 5'($urandom);
      logic [31:0] wdata = $urandom;
      int          hd    = $urandom_range(0, 6);
      int          cnt0  = dbg_wr_cnt;
      int          exp_lat = (hd <= 1) ? 2 : hd + 1;
      logic [31:0] exp_rd  = (we || addr == 5'd0) ? 32'h0 : exp_regs[addr];
      do_req(we, addr, wdata, hd, rd, er, lat, h);
      checks++; if (rd !== exp_rd || er !== 1'b0) begin errors++; $display("FAIL rand_rsp[%0d] we=%0b addr=%0d got rdata=%h err=%0b want %h/0", n, we, addr, rd, er, exp_rd); end
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rand_lat[%0d] got %0d want %0d", n, lat, exp_lat); end
      checks++; if (dbg_wr_cnt - cnt0 != int'(we)) begin errors++; $display("FAIL rand_pulses[%0d] got %0d want %0d", n, dbg_wr_cnt - cnt0, we); end
      if (we && addr != 5'd0) exp_regs[addr] = wdata;
    end
  endtask

  task automatic test_halt_timeout();
    logic [31:0] rd; logic er; int lat; logic h;
    int cnt0 = dbg_wr_cnt;
    do_req(1'b1, 5'd3, 32'hCAFE0001, 100000, rd, er, lat, h);
    checks++; if (lat != 255) begin errors++; $display("FAIL timeout_cycles got %0d want 255", lat); end
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL timeout_rsp got err=%0b rdata=%h want 1/0", er, rd); end
    checks++; if (dbg_wr_cnt != cnt0) begin errors++; $display("FAIL timeout_no_write got %0d pulses want 0", dbg_wr_cnt - cnt0); end
    checks++; if (h !== 1'b1 || bus.halt_o !== 1'b0) begin errors++; $display("FAIL timeout_halt got during=%0b after=%0b want 1/0", h, bus.halt_o); end
  endtask

  task automatic test_ex_stall();
    logic [31:0] rd; logic er; int lat; logic h;
    bus.halted_i = 1'b1;
    bus.dbg_req_valid_i = 1'b1; bus.dbg_req_we_i = 1'b1;
    bus.dbg_req_addr_i = 5'd9; bus.dbg_req_wdata_i = 32'h22;
    @(posedge clk); #1;
    bus.dbg_req_valid_i = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      bus.ex_we_i = 1'b1; bus.ex_waddr_i = 5'd7; bus.ex_wdata_i = 32'h11;
      #1;
      checks++; if (bus.regs_we_o !== 1'b1 || bus.regs_waddr_o !== 5'd7 || bus.regs_wdata_o !== 32'h11 || bus.dbg_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL stall_pass[%0d] got we=%0b addr=%0d data=%h valid=%0b want 1/7/11/0", i, bus.regs_we_o, bus.regs_waddr_o, bus.regs_wdata_o, bus.dbg_rsp_valid_o); end
      @(posedge clk); #1;
    end
    bus.ex_we_i = 1'b0;
    #1;
    checks++; if (bus.regs_we_o !== 1'b1 || bus.regs_waddr_o !== 5'd9 || bus.regs_wdata_o !== 32'h22) begin errors++; $display("FAIL stall_issue got we=%0b addr=%0d data=%h want 1/9/22", bus.regs_we_o, bus.regs_waddr_o, bus.regs_wdata_o); end
    @(posedge clk); #1;
    checks++; if (bus.dbg_rsp_valid_o !== 1'b1 || bus.dbg_rsp_err_o !== 1'b0) begin errors++; $display("FAIL stall_rsp got valid=%0b err=%0b want 1/0", bus.dbg_rsp_valid_o, bus.dbg_rsp_err_o); end
    bus.dbg_rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.dbg_rsp_ready_i = 1'b0;
    exp_regs[7] = 32'h11; exp_regs[9] = 32'h22;
    do_req(1'b0, 5'd7, 32'h0, 0, rd, er, lat, h);
    checks++; if (rd !== exp_regs[7]) begin errors++; $display("FAIL stall_read_x7 got %h want %h", rd, exp_regs[7]); end
    do_req(1'b0, 5'd9, 32'h0, 0, rd, er, lat, h);
    checks++; if (rd !== exp_regs[9]) begin errors++; $display("FAIL stall_read_x9 got %h want %h", rd, exp_regs[9]); end
  endtask

  task automatic test_forward();
    logic [31:0] rd; logic er; int lat; logic h;
    do_req(1'b1, 5'd3, 32'hAAAA5555, 0, rd, er, lat, h);
    bus.id_raddr2_i = 5'd17;
    bus.dbg_req_valid_i = 1'b1; bus.dbg_req_we_i = 1'b0; bus.dbg_req_addr_i = 5'd3;
    @(posedge clk); #1;
    bus.dbg_req_valid_i = 1'b0;
    checks++; if (bus.regs_raddr2_o !== 5'd17) begin errors++; $display("FAIL fwd_raddr_pass got %0d want 17", bus.regs_raddr2_o); end
    @(posedge clk); #1;
    bus.ex_we_i = 1'b1; bus.ex_waddr_i = 5'd3; bus.ex_wdata_i = 32'h1234;
    #1;
    checks++; if (bus.regs_raddr2_o !== 5'd3) begin errors++; $display("FAIL fwd_raddr_dbg got %0d want 3", bus.regs_raddr2_o); end
    @(posedge clk); #1;
    bus.ex_we_i = 1'b0;
    checks++; if (bus.dbg_rsp_valid_o !== 1'b1 || bus.dbg_rsp_rdata_o !== 32'h1234) begin errors++; $display("FAIL fwd_rdata got valid=%0b rdata=%h want 1/1234", bus.dbg_rsp_valid_o, bus.dbg_rsp_rdata_o); end
    bus.dbg_rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.dbg_rsp_ready_i = 1'b0;
    exp_regs[3] = 32'h1234;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; logic h;
    int cnt0 = dbg_wr_cnt;
    bus.halted_i = 1'b0;
    bus.dbg_req_valid_i = 1'b1; bus.dbg_req_we_i = 1'b1;
    bus.dbg_req_addr_i = 5'd5; bus.dbg_req_wdata_i = 32'h55;
    @(posedge clk); #1;
    bus.dbg_req_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.halt_o !== 1'b1) begin errors++; $display("FAIL mid_halt_before got %0b want 1", bus.halt_o); end
    rst = 1'b1; bus.halted_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.halt_o !== 1'b0 || bus.dbg_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL mid_abort got halt=%0b valid=%0b want 0/0", bus.halt_o, bus.dbg_rsp_valid_o); end
    @(posedge clk); #1;
    do_req(1'b0, 5'd5, 32'h0, 0, rd, er, lat, h);
    checks++; if (rd !== exp_regs[5] || er !== 1'b0 || lat != 2) begin errors++; $display("FAIL mid_after got rdata=%h err=%0b lat=%0d want %h/0/2", rd, er, lat, exp_regs[5]); end
    checks++; if (dbg_wr_cnt != cnt0) begin errors++; $display("FAIL mid_no_write got %0d pulses want 0", dbg_wr_cnt - cnt0); end
  endtask

  task automatic test_backpressure();
    int wait_cyc = 0;
    bus.halted_i = 1'b1;
    bus.dbg_req_valid_i = 1'b1; bus.dbg_req_we_i = 1'b0; bus.dbg_req_addr_i = 5'd9;
    @(posedge clk); #1;
    bus.dbg_req_valid_i = 1'b0;
    while (!bus.dbg_rsp_valid_o && wait_cyc < 10) begin
      wait_cyc++;
      @(posedge clk); #1;
    end
    checks++; if (bus.dbg_rsp_valid_o !== 1'b1) begin errors++; $display("FAIL bp_rsp_timeout got valid=%0b want 1", bus.dbg_rsp_valid_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.dbg_rsp_valid_o !== 1'b1 || bus.dbg_rsp_rdata_o !== exp_regs[9] || bus.dbg_rsp_err_o !== 1'b0 || bus.dbg_req_ready_o !== 1'b0 || bus.halt_o !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got valid=%0b rdata=%h err=%0b ready=%0b halt=%0b want 1/%h/0/0/1", i, bus.dbg_rsp_valid_o, bus.dbg_rsp_rdata_o, bus.dbg_rsp_err_o, bus.dbg_req_ready_o, bus.halt_o, exp_regs[9]); end
      @(posedge clk); #1;
    end
    bus.dbg_rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.dbg_rsp_ready_i = 1'b0;
    checks++; if (bus.halt_o !== 1'b0 || bus.dbg_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL bp_release got halt=%0b valid=%0b want 0/0", bus.halt_o, bus.dbg_rsp_valid_o); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) exp_regs[i] = '0;
    test_reset();
    test_write_latency();
    test_x0();
    test_random();
    test_halt_timeout();
    test_ex_stall();
    test_forward();
    test_reset_mid();
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
